// File: rtl/tlp_mwr_hdr_gen.sv
// tlp_mwr_hdr_gen: splits DMA write requests into PCIe MWr TLP headers at max-payload and 4 KB boundaries.
module tlp_mwr_hdr_gen #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           my_id,
  input  logic                  my_id_valid,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_addr,
  input  logic [10:0]           req_len_dw,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [127:0]          hdr_data,
  output logic [10:0]           hdr_len_dw,
  output logic                  hdr_last,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_ID = 2'd1, EMIT = 2'd2;
  localparam logic [10:0] MAX_DW = 11'(MAX_PAYLOAD_DW);
  logic [1:0]            r_state;
  logic [61:0]           r_addr;
  logic [10:0]           r_rem;
  logic [15:0]           r_id;
  logic [7:0]            r_tag;
  logic [DROP_CNT_W-1:0] r_drop;
  logic [10:0]           w_room, w_min_mp, w_chunk;
  logic                  w_4dw, w_bad, w_unused;
  assign w_unused = ^req_addr[1:0];
  // DW left before the next 4 KB page boundary (1..1024)
  assign w_room = 11'd1024 - {1'b0, r_addr[9:0]};
  assign w_min_mp = (r_rem < MAX_DW) ? r_rem : MAX_DW;
  assign w_chunk = (w_min_mp < w_room) ? w_min_mp : w_room;
  assign w_4dw = |r_addr[61:30];
  assign w_bad = (req_len_dw == 11'd0) | (req_len_dw > 11'd1024);
  assign req_ready = reset_n & (r_state == IDLE);
  assign hdr_valid = (r_state == EMIT);
  assign hdr_len_dw = w_chunk;
  assign hdr_last = (r_rem == w_chunk);
  assign drop_count = r_drop;
  assign hdr_data[31:0] = {w_4dw ? 3'b011 : 3'b010, 19'd0, w_chunk[9:0]};
  assign hdr_data[63:32] = {r_id, r_tag, (w_chunk > 11'd1) ? 4'hF : 4'h0, 4'hF};
  assign hdr_data[95:64] = w_4dw ? r_addr[61:30] : {r_addr[29:0], 2'b00};
  assign hdr_data[127:96] = w_4dw ? {r_addr[29:0], 2'b00} : 32'd0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_rem <= '0;
      r_id <= '0;
      r_tag <= '0;
      r_drop <= '0;
    end else if (r_state == IDLE && req_valid) begin
      if (w_bad) begin
        if (~&r_drop) r_drop <= r_drop + 1'b1;
      end else begin
        r_addr <= req_addr[63:2];
        r_rem <= req_len_dw;
        if (my_id_valid) r_id <= my_id;
        r_state <= my_id_valid ? EMIT : WAIT_ID;
      end
    end else if (r_state == WAIT_ID && my_id_valid) begin
      r_id <= my_id;
      r_state <= EMIT;
    end else if (r_state == EMIT && hdr_ready) begin
      r_addr <= r_addr + 62'(w_chunk);
      r_rem <= r_rem - w_chunk;
      r_tag <= r_tag + 8'd1;
      if (hdr_last) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_tlp_mwr_hdr_gen.sv
// tb_tlp_mwr_hdr_gen: scoreboard bench for the MWr header generator.
module tb_tlp_mwr_hdr_gen;
  logic         clk = 0;
  logic         reset_n = 0;
  logic [15:0]  my_id = 0;
  logic         my_id_valid = 0;
  logic         req_valid = 0;
  logic         req_ready;
  logic [63:0]  req_addr = 0;
  logic [10:0]  req_len_dw = 0;
  logic         hdr_valid;
  logic         hdr_ready = 0;
  logic [127:0] hdr_data;
  logic [10:0]  hdr_len_dw;
  logic         hdr_last;
  logic [7:0]   drop_count;

  typedef struct {
    logic [127:0] d;
    logic [10:0]  l;
    logic         last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] exp_tag = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  tlp_mwr_hdr_gen #(.MAX_PAYLOAD_DW(32), .DROP_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .my_id(my_id), .my_id_valid(my_id_valid),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len_dw(req_len_dw), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_data(hdr_data), .hdr_len_dw(hdr_len_dw), .hdr_last(hdr_last),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Handshake happens at the next posedge; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (reset_n && hdr_valid && hdr_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_hdr: got data=%h len=%0d last=%0b, expected none", hdr_data, hdr_len_dw, hdr_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (hdr_data !== e.d || hdr_len_dw !== e.l || hdr_last !== e.last) begin
          n_bad++;
          $display("FAIL sb_hdr: got data=%h len=%0d last=%0b, expected data=%h len=%0d last=%0b", hdr_data, hdr_len_dw, hdr_last, e.d, e.l, e.last);
        end
      end
    end
  end

  task automatic push_req(input logic [63:0] a, input int len, input logic [15:0] id);
    logic [61:0] dw;
    int rem, room, c;
    logic four;
    exp_t e;
    dw = a[63:2];
    rem = len;
    while (rem > 0) begin
      room = 1024 - int'(dw[9:0]);
      c = rem;
      if (c > 32) c = 32;
      if (c > room) c = room;
      four = (dw[61:30] != 0);
      e.d[31:0] = {four ? 3'b011 : 3'b010, 19'd0, c[9:0]};
      e.d[63:32] = {id, exp_tag, (c > 1) ? 4'hF : 4'h0, 4'hF};
      e.d[95:64] = four ? dw[61:30] : {dw[29:0], 2'b00};
      e.d[127:96] = four ? {dw[29:0], 2'b00} : 32'd0;
      e.l = c[10:0];
      e.last = (rem == c);
      q.push_back(e);
      exp_tag++;
      dw += 62'(c);
      rem -= c;
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [10:0] len);
    int k;
    @(posedge clk); #1;
    req_valid = 1;
    req_addr = a;
    req_len_dw = len;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 50);
    n_cmp++;
    if (!req_ready) begin
      n_bad++;
      $display("FAIL req_accept_timeout: req_ready=%0b, expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d headers outstanding, expected 0", nm, q.size());
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (hdr_valid !== 0 || req_ready !== 0 || drop_count !== 0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%0b ready=%0b drop=%0d, expected 0 0 0", hdr_valid, req_ready, drop_count);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1 || hdr_valid !== 0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%0b valid=%0b, expected 1 0", req_ready, hdr_valid);
    end
  endtask

  task automatic test_single;
    my_id = 16'hB300;
    my_id_valid = 1;
    hdr_ready = 1;
    push_req(64'h1000, 1, 16'hB300);
    send(64'h1000, 11'd1);
    @(negedge clk);
    n_cmp++;
    if (hdr_valid !== 1 || hdr_data !== 128'h00000000_00001000_B300000F_40000001 || hdr_last !== 1) begin
      n_bad++;
      $display("FAIL single_hdr: valid=%0b data=%h last=%0b, expected 1 %h 1", hdr_valid, hdr_data, hdr_last, 128'h00000000_00001000_B300000F_40000001);
    end
    drain("single");
  endtask

  task automatic test_split;
    logic [10:0] lens[4];
    lens = '{11'd4, 11'd32, 11'd32, 11'd32};
    push_req(64'h0FF0, 100, 16'hB300);
    send(64'h0FF0, 11'd100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (hdr_valid !== 1 || hdr_len_dw !== lens[i] || hdr_last !== (i == 3) || hdr_data[47:40] !== 8'(i + 1)) begin
        n_bad++;
        $display("FAIL split_frag%0d: valid=%0b len=%0d last=%0b tag=%0d, expected 1 %0d %0b %0d", i, hdr_valid, hdr_len_dw, hdr_last, hdr_data[47:40], lens[i], i == 3, i + 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (hdr_valid !== 0) begin
      n_bad++;
      $display("FAIL split_end: valid=%0b, expected 0", hdr_valid);
    end
    drain("split");
  endtask

  task automatic test_4dw;
    push_req(64'h1_0000_0000, 2, 16'hB300);
    send(64'h1_0000_0000, 11'd2);
    @(negedge clk);
    n_cmp++;
    if (hdr_data[31:29] !== 3'b011 || hdr_data[95:64] !== 32'h1 || hdr_data[127:96] !== 32'h0 || hdr_data[39:36] !== 4'hF) begin
      n_bad++;
      $display("FAIL four_dw: fmt=%b dw2=%h dw3=%h lastbe=%h, expected 011 00000001 00000000 f", hdr_data[31:29], hdr_data[95:64], hdr_data[127:96], hdr_data[39:36]);
    end
    drain("four_dw");
    push_req(64'hFFFF_FFF8, 4, 16'hB300);
    send(64'hFFFF_FFF8, 11'd4);
    drain("cross_4g");
  endtask

  task automatic test_wait_id;
    my_id_valid = 0;
    my_id = 16'h0100;
    push_req(64'h2000, 1, 16'h0100);
    send(64'h2000, 11'd1);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (hdr_valid !== 0 || req_ready !== 0) begin
        n_bad++;
        $display("FAIL wait_id_idle: valid=%0b ready=%0b, expected 0 0", hdr_valid, req_ready);
      end
    end
    @(posedge clk); #1;
    my_id_valid = 1;
    @(negedge clk);
    n_cmp++;
    if (hdr_valid !== 0) begin
      n_bad++;
      $display("FAIL wait_id_early: valid=%0b, expected 0", hdr_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (hdr_valid !== 1 || hdr_data[63:48] !== 16'h0100) begin
      n_bad++;
      $display("FAIL wait_id_hdr: valid=%0b id=%h, expected 1 0100", hdr_valid, hdr_data[63:48]);
    end
    drain("wait_id");
  endtask

  task automatic test_backpressure;
    logic [127:0] d0;
    logic [10:0]  l0;
    logic         t0;
    my_id = 16'hB300;
    hdr_ready = 0;
    push_req(64'h0, 100, 16'hB300);
    send(64'h0, 11'd100);
    @(posedge clk); #1;
    hdr_ready = 1;
    @(posedge clk); #1;
    hdr_ready = 0;
    my_id = 16'hFFFF;
    @(negedge clk);
    d0 = hdr_data;
    l0 = hdr_len_dw;
    t0 = hdr_last;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (hdr_valid !== 1 || hdr_data !== d0 || hdr_len_dw !== l0 || hdr_last !== t0 || req_ready !== 0) begin
        n_bad++;
        $display("FAIL hold_stable: valid=%0b data=%h len=%0d ready=%0b, expected 1 %h %0d 0", hdr_valid, hdr_data, hdr_len_dw, req_ready, d0, l0);
      end
    end
    @(posedge clk); #1;
    hdr_ready = 1;
    drain("backpressure");
    my_id = 16'hB300;
    send(64'h3000, 11'd0);
    send(64'h3000, 11'd1025);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (drop_count !== 8'd2 || hdr_valid !== 0) begin
      n_bad++;
      $display("FAIL drop_count: drop=%0d valid=%0b, expected 2 0", drop_count, hdr_valid);
    end
  endtask

  task automatic test_reset_mid;
    push_req(64'h0, 128, 16'hB300);
    send(64'h0, 11'd128);
    @(posedge clk); #1;
    hdr_ready = 0;
    @(negedge clk);
    #1 reset_n = 0;
    #1;
    n_cmp++;
    if (hdr_valid !== 0 || req_ready !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_async: valid=%0b ready=%0b, expected 0 0", hdr_valid, req_ready);
    end
    q.delete();
    exp_tag = 0;
    hdr_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (hdr_valid !== 0 || req_ready !== 1 || drop_count !== 0) begin
        n_bad++;
        $display("FAIL reset_mid_idle: valid=%0b ready=%0b drop=%0d, expected 0 1 0", hdr_valid, req_ready, drop_count);
      end
    end
    push_req(64'h4000, 1, 16'hB300);
    send(64'h4000, 11'd1);
    @(negedge clk);
    n_cmp++;
    if (hdr_valid !== 1 || hdr_data[47:40] !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_tag: valid=%0b tag=%0d, expected 1 0", hdr_valid, hdr_data[47:40]);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_4dw();
    test_wait_id();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
